// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Bit-serial magnitude comparator for two WIDTH-bit unsigned operands.
//   Operands are captured on an accepted start and scanned MSB-first, one bit
//   per clock. The first bit position where the operands differ decides the
//   relation. That relation is sticky, so lower bits cannot overturn it.
//
//   Build option: define EARLY_TERM_EN to leave SCAN as soon as the relation
//   is decided. Equal operands still scan all WIDTH bits. The G/L values are
//   the same in both builds; only the latency changes.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request, accepted when start & ready
//   X, Y   in   WIDTH  operands, sampled only on acceptance
//   ready  out  1      able to accept start (IDLE or DONE)
//   busy   out  1      scan in progress
//   done   out  1      one-cycle pulse, G/L valid
//   G      out  1      X > Y (held until the next accepted start)
//   L      out  1      Y > X (held until the next accepted start)

module serial_mag_comp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             L
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_e;

  state_e           state_q, state_d;
  rel_e             rel_q,   rel_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] xs_q,    xs_d;
  logic [WIDTH-1:0] ys_q,    ys_d;
  logic             g_q,     g_d;
  logic             l_q,     l_d;
  logic             scan_end;

  // Control state is reset. The operand shift registers are data and are
  // always reloaded on acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      cnt_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      l_q     <= l_d;
    end
  end

  always_ff @(posedge clk) begin
    xs_q <= xs_d;
    ys_q <= ys_d;
  end

  always_comb begin
    state_d  = state_q;
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    g_d      = g_q;
    l_d      = l_q;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    scan_end = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = SCAN;
          xs_d    = X;
          ys_d    = Y;
          rel_d   = REL_EQ;
          cnt_d   = CW'(WIDTH - 1);
          g_d     = 1'b0;
          l_d     = 1'b0;
        end
      end

      SCAN: begin
        busy = 1'b1;
        // Only the first differing bit (from the MSB down) decides the result.
        if (rel_q == REL_EQ) begin
          if (xs_q[WIDTH-1] && !ys_q[WIDTH-1]) begin
            rel_d = REL_GT;
          end else if (!xs_q[WIDTH-1] && ys_q[WIDTH-1]) begin
            rel_d = REL_LT;
          end
        end
        xs_d  = {xs_q[WIDTH-2:0], 1'b0};
        ys_d  = {ys_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);

        scan_end = (cnt_q == '0);
`ifdef EARLY_TERM_EN
        if (rel_d != REL_EQ) begin
          scan_end = 1'b1;
        end
`endif
        // G/L are registered on the way into DONE so they are valid with done.
        if (scan_end) begin
          state_d = DONE;
          g_d     = (rel_d == REL_GT);
          l_d     = (rel_d == REL_LT);
        end
      end

      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          state_d = SCAN;
          xs_d    = X;
          ys_d    = Y;
          rel_d   = REL_EQ;
          cnt_d   = CW'(WIDTH - 1);
          g_d     = 1'b0;
          l_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign G = g_q;
  assign L = l_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp. It drives a WIDTH=4 instance and a
// WIDTH=8 instance. Latencies are counted in cycles from the acceptance edge
// t, so done in cycle t+WIDTH+1 is counted as WIDTH+1.
module tb_serial_mag_comp;

  logic       clk;
  logic       rst;
  logic       st4, st8;
  logic [3:0] x4, y4;
  logic [7:0] x8, y8;
  logic       rdy4, bsy4, dn4, g4, l4;
  logic       rdy8, bsy8, dn8, g8, l8;

  int checks = 0;
  int errors = 0;

  serial_mag_comp #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .X(x4), .Y(y4),
    .ready(rdy4), .busy(bsy4), .done(dn4), .G(g4), .L(l4)
  );

  serial_mag_comp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .X(x8), .Y(y8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .G(g8), .L(l8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the acceptance edge to the done cycle.
  function automatic int model_lat(input logic [7:0] x, input logic [7:0] y, input int w);
`ifdef EARLY_TERM_EN
    for (int i = w - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return (w - i) + 1;
    end
`endif
    return w + 1;
  endfunction

  // One complete compare: accept, check busy, wait for done, then check that
  // done falls and that G/L hold their values.
  task automatic run_op(input bit w8, input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input logic exp_g, input logic exp_l,
                        input string tag);
    int n;
    @(negedge clk);
    if (w8) begin x8 = x; y8 = y; st8 = 1'b1; end
    else begin x4 = x[3:0]; y4 = y[3:0]; st4 = 1'b1; end
    @(posedge clk);
    #1;
    st4 = 1'b0;
    st8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " busy"},  w8 ? bsy8 : bsy4, 1'b1);
        chk({tag, " ready"}, w8 ? rdy8 : rdy4, 1'b0);
      end
    end while (!(w8 ? dn8 : dn4) && n < 24);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " G"}, w8 ? g8 : g4, exp_g);
    chk({tag, " L"}, w8 ? l8 : l4, exp_l);
    @(negedge clk);
    chk({tag, " done drop"}, w8 ? dn8 : dn4, 1'b0);
    chk({tag, " G hold"}, w8 ? g8 : g4, exp_g);
    chk({tag, " L hold"}, w8 ? l8 : l4, exp_l);
  endtask

  initial begin
    int n;
    int ndone;
    int ndone_rst;
    logic [7:0] rx, ry;

    rst = 1'b1; st4 = 1'b0; st8 = 1'b0;
    x4 = '0; y4 = '0; x8 = '0; y8 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst ready4", rdy4, 1'b1);
    chk("rst busy4",  bsy4, 1'b0);
    chk("rst done4",  dn4,  1'b0);
    chk("rst G4",     g4,   1'b0);
    chk("rst L4",     l4,   1'b0);
    chk("rst ready8", rdy8, 1'b1);
    chk("rst G8",     g8,   1'b0);

    // 1: 9 vs 5, MSB differs first
`ifdef EARLY_TERM_EN
    run_op(1'b0, 8'd9, 8'd5, 2, 1'b1, 1'b0, "t1 9>5");
`else
    run_op(1'b0, 8'd9, 8'd5, 5, 1'b1, 1'b0, "t1 9>5");
`endif
    // G stays high in IDLE until the next accepted start.
    @(negedge clk);
    chk("t1 G idle hold", g4, 1'b1);

    // 2: equal operands take the full latency in both builds.
    run_op(1'b0, 8'd7, 8'd7, 5, 1'b0, 1'b0, "t2 7==7");

    // 3: 3 vs 12
`ifdef EARLY_TERM_EN
    run_op(1'b0, 8'd3, 8'd12, 2, 1'b0, 1'b1, "t3 3<12");
`else
    run_op(1'b0, 8'd3, 8'd12, 5, 1'b0, 1'b1, "t3 3<12");
`endif
    // 12 vs 13 (1100 vs 1101) differ only in the LSB, so this is the full scan.
    run_op(1'b0, 8'd12, 8'd13, 5, 1'b0, 1'b1, "t3b 12<13");
    // 0x80 vs 0x7F at WIDTH=8 differ in the MSB.
`ifdef EARLY_TERM_EN
    run_op(1'b1, 8'h80, 8'h7F, 2, 1'b1, 1'b0, "t3c 80>7f");
`else
    run_op(1'b1, 8'h80, 8'h7F, 9, 1'b1, 1'b0, "t3c 80>7f");
`endif

    // rst and start in the same cycle: rst wins.
    @(negedge clk);
    rst = 1'b1; st4 = 1'b1; x4 = 4'd15; y4 = 4'd0;
    @(posedge clk);
    #1 rst = 1'b0; st4 = 1'b0;
    @(negedge clk);
    chk("rst+start busy",  bsy4, 1'b0);
    chk("rst+start ready", rdy4, 1'b1);
    chk("rst+start L",     l4,   1'b0);

    // 4: rst in the 2nd SCAN cycle aborts with no done pulse.
    @(negedge clk);
    x4 = 4'd6; y4 = 4'd6; st4 = 1'b1;
    @(posedge clk);
    #1 st4 = 1'b0;
    @(negedge clk);
    chk("t4 scan1 busy", bsy4, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4 ready", rdy4, 1'b1);
    chk("t4 busy",  bsy4, 1'b0);
    chk("t4 done",  dn4,  1'b0);
    chk("t4 G",     g4,   1'b0);
    chk("t4 L",     l4,   1'b0);
    ndone_rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (dn4) ndone_rst++;
    end
    chk("t4 no done pulse", ndone_rst, 0);
`ifdef EARLY_TERM_EN
    run_op(1'b0, 8'd10, 8'd2, 2, 1'b1, 1'b0, "t4 after rst");
`else
    run_op(1'b0, 8'd10, 8'd2, 5, 1'b1, 1'b0, "t4 after rst");
`endif

    // 5: start held high while X/Y toggle. Only the accepted operands count.
    // A start held in DONE reloads at once (back-to-back).
    @(negedge clk);
    x4 = 4'd9; y4 = 4'd5; st4 = 1'b1;
    @(posedge clk);
    n = 0;
    ndone = 0;
    while (ndone < 2 && n < 24) begin
      @(negedge clk);
      n++;
      if (dn4) begin
        if (ndone == 0) begin
`ifdef EARLY_TERM_EN
          chk("t5 first latency", n, 2);
`else
          chk("t5 first latency", n, 5);
`endif
          chk("t5 first G", g4, 1'b1);
          chk("t5 first L", l4, 1'b0);
          chk("t5 ready in done", rdy4, 1'b1);
          x4 = 4'd3; y4 = 4'd12;
          n = 0;
        end else begin
`ifdef EARLY_TERM_EN
          chk("t5 b2b latency", n, 2);
`else
          chk("t5 b2b latency", n, 5);
`endif
          chk("t5 b2b G", g4, 1'b0);
          chk("t5 b2b L", l4, 1'b1);
          st4 = 1'b0;
        end
        ndone++;
      end else if (ndone == 0) begin
        x4 = 4'd0;  y4 = 4'd15;
      end else begin
        x4 = 4'd15; y4 = 4'd0;
      end
    end
    chk("t5 done count", ndone, 2);
    st4 = 1'b0;
    @(negedge clk);

    // 6: random pairs checked against the parallel comparator.
    for (int i = 0; i < 500; i++) begin
      rx = 8'($urandom_range(0, 15));
      ry = 8'($urandom_range(0, 15));
      run_op(1'b0, rx, ry, model_lat(rx, ry, 4), rx > ry, ry > rx,
             $sformatf("rnd4 %0d x=%0d y=%0d", i, rx, ry));
    end
    for (int i = 0; i < 500; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = (i % 4 == 0) ? rx : 8'($urandom_range(0, 255));
      run_op(1'b1, rx, ry, model_lat(rx, ry, 8), rx > ry, ry > rx,
             $sformatf("rnd8 %0d x=%0d y=%0d", i, rx, ry));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
